// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the four-pixel BRAM reader.
package bram_reader_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One address per pixel is issued during FETCH.
  localparam int FETCH_LEN = 4;
  // Cycles spent draining the BRAM read pipeline after the last address.
  localparam int FLUSH_LEN = 2;

  // Width of the pixel-slot index for a given packing factor (minimum 1 bit).
  function automatic int idx_width(input int pixels_per_word);
    return (pixels_per_word > 1) ? $clog2(pixels_per_word) : 1;
  endfunction

endpackage

// File: rtl/bram_reader_pixel_select.sv
// Picks one pixel out of a packed BRAM word; slot 0 is the least significant pixel.
module pixel_select
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int PIXEL_PER_ADDRESS = 8,
  parameter int BITS_PER_PIXEL    = 8,
  localparam int IDX_W            = idx_width(PIXEL_PER_ADDRESS)
) (
  input  logic [DATA_WIDTH-1:0]     word,
  input  logic [IDX_W-1:0]          idx,
  output logic [BITS_PER_PIXEL-1:0] pixel
);

  assign pixel = word[int'(idx) * BITS_PER_PIXEL +: BITS_PER_PIXEL];

endmodule

// File: rtl/bram_reader.sv
// Four-pixel fetcher for a single-port, one-cycle-latency BRAM.
// Build option: define BRAM_READER_RANGE_CHECK_EN to map out-of-range
// addresses to word 0 and force the corresponding pixel to zero.
module bram_reader
  import bram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH        = 14,
  parameter int DATA_WIDTH        = 64,
  parameter int PIXEL_PER_ADDRESS = 8,
  parameter int BITS_PER_PIXEL    = 8,
  parameter int MEM_DEPTH         = 9600,
  localparam int IDX_W            = idx_width(PIXEL_PER_ADDRESS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     pixel_addr_tl,
  input  logic [ADDR_WIDTH-1:0]     pixel_addr_tr,
  input  logic [ADDR_WIDTH-1:0]     pixel_addr_bl,
  input  logic [ADDR_WIDTH-1:0]     pixel_addr_br,
  input  logic [IDX_W-1:0]          pixel_row_index_tl,
  input  logic [IDX_W-1:0]          pixel_row_index_tr,
  input  logic [IDX_W-1:0]          pixel_row_index_bl,
  input  logic [IDX_W-1:0]          pixel_row_index_br,
  input  logic [DATA_WIDTH-1:0]     bram_out,
  output logic [ADDR_WIDTH-1:0]     bram_addr,
  output logic                      bram_we,
  output logic                      data_valid,
  output logic [BITS_PER_PIXEL-1:0] pixel_tl,
  output logic [BITS_PER_PIXEL-1:0] pixel_tr,
  output logic [BITS_PER_PIXEL-1:0] pixel_bl,
  output logic [BITS_PER_PIXEL-1:0] pixel_br
);

`ifdef BRAM_READER_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  localparam int STEP_W = 3;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [STEP_W-1:0] LAST_FETCH = STEP_W'(FETCH_LEN - 1);
  localparam logic [STEP_W-1:0] LAST_FLUSH = STEP_W'(FETCH_LEN + FLUSH_LEN - 1);
  localparam logic [STEP_W-1:0] FIRST_CAP  = STEP_W'(2);

  state_e                    state_q, state_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [ADDR_WIDTH-1:0]     addr_q [0:3];
  logic [ADDR_WIDTH-1:0]     addr_d [0:3];
  logic [IDX_W-1:0]          idx_q [0:3];
  logic [IDX_W-1:0]          idx_d [0:3];
  logic [ADDR_WIDTH-1:0]     bram_addr_q, bram_addr_d;
  logic                      data_valid_q, data_valid_d;
  logic [BITS_PER_PIXEL-1:0] pixels [0:3];
  logic [BITS_PER_PIXEL-1:0] pixels_d [0:3];
  logic [BITS_PER_PIXEL-1:0] pix_out_q [0:3];
  logic [BITS_PER_PIXEL-1:0] pix_out_d [0:3];

  logic [1:0]                issue_slot, cap_slot;
  logic [ADDR_WIDTH-1:0]     issue_addr;
  logic [BITS_PER_PIXEL-1:0] sel_pixel, cap_pixel;

  // Slot addressed this cycle, and the slot whose word is arriving (two edges behind).
  assign issue_slot = step_q[1:0];
  assign cap_slot   = 2'(step_q - FIRST_CAP);

  pixel_select #(
    .DATA_WIDTH        (DATA_WIDTH),
    .PIXEL_PER_ADDRESS (PIXEL_PER_ADDRESS),
    .BITS_PER_PIXEL    (BITS_PER_PIXEL)
  ) u_pixel_select (
    .word  (bram_out),
    .idx   (idx_q[cap_slot]),
    .pixel (sel_pixel)
  );

  // Optional out-of-range mapping of the issued address and the captured pixel.
  always_comb begin
    issue_addr = addr_q[issue_slot];
    cap_pixel  = sel_pixel;
    if (RANGE_CHECK && ({1'b0, addr_q[issue_slot]} >= DEPTH_L)) issue_addr = '0;
    if (RANGE_CHECK && ({1'b0, addr_q[cap_slot]} >= DEPTH_L))   cap_pixel  = '0;
  end

  // Next-state and datapath update for the fetch sequence.
  // NOTE: every signal is given its default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    bram_addr_d  = bram_addr_q;
    data_valid_d = 1'b0;
    pixels_d     = pixels;
    pix_out_d    = pix_out_q;

    unique case (state_q)
      // DONE is also the earliest slot a back-to-back request can be accepted in,
      // which keeps a held start at one result every seven cycles.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_d  = '{pixel_addr_tl, pixel_addr_tr, pixel_addr_bl, pixel_addr_br};
          idx_d   = '{pixel_row_index_tl, pixel_row_index_tr,
                      pixel_row_index_bl, pixel_row_index_br};
          step_d  = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        bram_addr_d = issue_addr;
        if (step_q >= FIRST_CAP) pixels_d[cap_slot] = cap_pixel;
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_FETCH) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        pixels_d[cap_slot] = cap_pixel;
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_FLUSH) begin
          pix_out_d    = pixels_d;
          data_valid_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Datapath registers; the latched request needs no reset because it is always
  // written on the accepting edge before it is read.
  // NOTE: storage arrays that are written before use are left out of reset.
  always_ff @(posedge clk) begin
    addr_d_copy: begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
    end
    if (!rst) begin
      step_q       <= '0;
      bram_addr_q  <= '0;
      data_valid_q <= 1'b0;
      pixels       <= '{default: '0};
      pix_out_q    <= '{default: '0};
    end else begin
      step_q       <= step_d;
      bram_addr_q  <= bram_addr_d;
      data_valid_q <= data_valid_d;
      pixels       <= pixels_d;
      pix_out_q    <= pix_out_d;
    end
  end

  assign bram_addr  = bram_addr_q;
  assign bram_we    = 1'b0;
  assign data_valid = data_valid_q;
  assign pixel_tl   = pix_out_q[0];
  assign pixel_tr   = pix_out_q[1];
  assign pixel_bl   = pix_out_q[2];
  assign pixel_br   = pix_out_q[3];

endmodule

// File: tb/tb_bram_reader.sv
// Self-checking bench for bram_reader with a behavioural one-cycle-latency BRAM.
// Expectations follow BRAM_READER_RANGE_CHECK_EN when it is defined for the build.
module tb_bram_reader;

  localparam int AW = 14;
  localparam int DW = 64;
  localparam int IW = 3;
  localparam int PW = 8;
  localparam int WORDS = 1 << AW;

  typedef struct packed {
    logic [3:0][AW-1:0] addr;
    logic [3:0][IW-1:0] idx;
    logic [3:0][PW-1:0] exp;
  } vec_t;

  logic clk, rst, start;
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  logic [IW-1:0] i_tl, i_tr, i_bl, i_br;
  logic [DW-1:0] bram_out;
  logic [AW-1:0] bram_addr;
  logic bram_we, data_valid;
  logic [PW-1:0] pixel_tl, pixel_tr, pixel_bl, pixel_br;

  logic [DW-1:0] mem [0:WORDS-1];
  logic [DW-1:0] ref_mem [0:WORDS-1];
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] mux_addr;
  logic mux_we;
  logic [DW-1:0] mux_wdata;

  int checks = 0;
  int errors = 0;
  int we_bad = 0;
  int addr_bad = 0;

  bram_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .pixel_addr_tl(a_tl), .pixel_addr_tr(a_tr), .pixel_addr_bl(a_bl), .pixel_addr_br(a_br),
    .pixel_row_index_tl(i_tl), .pixel_row_index_tr(i_tr),
    .pixel_row_index_bl(i_bl), .pixel_row_index_br(i_br),
    .bram_out(bram_out), .bram_addr(bram_addr), .bram_we(bram_we),
    .data_valid(data_valid),
    .pixel_tl(pixel_tl), .pixel_tr(pixel_tr), .pixel_bl(pixel_bl), .pixel_br(pixel_br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side write port muxed in front of the DUT's port.
  assign mux_addr  = ld_en ? ld_addr : bram_addr;
  assign mux_we    = ld_en | bram_we;
  assign mux_wdata = ld_en ? ld_data : '0;

  always @(posedge clk) begin
    if (mux_we) mem[mux_addr] <= mux_wdata;
    bram_out <= mem[mux_addr];
  end

  // Continuous watch on the write enable and the issued address range.
  always @(negedge clk) begin
    if (bram_we !== 1'b0) we_bad++;
`ifdef BRAM_READER_RANGE_CHECK_EN
    if (bram_addr > AW'(9599)) addr_bad++;
`endif
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_pixel(input logic [AW-1:0] a, input logic [IW-1:0] i);
    logic [DW-1:0] w;
`ifdef BRAM_READER_RANGE_CHECK_EN
    if (a >= AW'(9600)) return '0;
`endif
    w = ref_mem[a];
    return w[int'(i) * PW +: PW];
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef BRAM_READER_RANGE_CHECK_EN
    if (a >= AW'(9600)) return '0;
`endif
    return a;
  endfunction

  function automatic vec_t mk(input logic [AW-1:0] a0, a1, a2, a3,
                              input logic [IW-1:0] x0, x1, x2, x3);
    vec_t v;
    v.addr = {a3, a2, a1, a0};
    v.idx  = {x3, x2, x1, x0};
    for (int s = 0; s < 4; s++) v.exp[s] = exp_pixel(v.addr[s], v.idx[s]);
    return v;
  endfunction

  task automatic set_inputs(input vec_t v);
    a_tl = v.addr[0]; a_tr = v.addr[1]; a_bl = v.addr[2]; a_br = v.addr[3];
    i_tl = v.idx[0];  i_tr = v.idx[1];  i_bl = v.idx[2];  i_br = v.idx[3];
  endtask

  function automatic logic [31:0] got_pixels();
    return {pixel_br, pixel_bl, pixel_tr, pixel_tl};
  endfunction

  // One-cycle start pulse, optional input change before edge 2, full result check.
  task automatic run_vector(input string name, input vec_t v, input bit change, input vec_t alt);
    logic [3:0][AW-1:0] seen, exp_seq;
    int lat;
    seen = '0;
    lat = -1;
    set_inputs(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 4) seen[k-1] = bram_addr;
      if (change && k == 1) set_inputs(alt);
      if (data_valid) begin
        lat = k;
        break;
      end
    end
    for (int s = 0; s < 4; s++) exp_seq[s] = exp_addr(v.addr[s]);
    check($sformatf("%s latency", name), 64'(lat), 64'd6);
    check($sformatf("%s addr order", name), 64'(seen), 64'(exp_seq));
    check($sformatf("%s pixels", name), 64'(got_pixels()), 64'(v.exp));
    check($sformatf("%s array", name),
          64'({dut.pixels[3], dut.pixels[2], dut.pixels[1], dut.pixels[0]}), 64'(v.exp));
    @(negedge clk);
    check($sformatf("%s valid one cycle", name), 64'(data_valid), 64'd0);
    check($sformatf("%s pixels hold", name), 64'(got_pixels()), 64'(v.exp));
  endtask

  initial begin
    vec_t vecs [5];
    vec_t vm1, va, vb, vnone;
    int npulse, p0, p1;

    rst = 1'b0; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    vnone = '0;
    set_inputs(vnone);

    for (int i = 0; i < WORDS; i++) ref_mem[i] = {$urandom, $urandom};

    repeat (3) @(negedge clk);
    check("reset bram_addr", 64'(bram_addr), 64'd0);
    check("reset data_valid", 64'(data_valid), 64'd0);
    check("reset pixels", 64'(got_pixels()), 64'd0);
    check("reset bram_we", 64'(bram_we), 64'd0);
    rst = 1'b1;

    // Load the whole address space through the bench write port.
    for (int i = 0; i < WORDS; i++) begin
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = ref_mem[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
    @(negedge clk);

    vecs[0] = mk(AW'(0), AW'(0), AW'(40), AW'(40), 3'd0, 3'd1, 3'd0, 3'd1);
    vecs[1] = mk(AW'(9599), AW'(1), AW'(8191), AW'(5000), 3'd7, 3'd3, 3'd5, 3'd2);
    vecs[2] = mk(AW'(100), AW'(101), AW'(102), AW'(103), 3'd6, 3'd6, 3'd6, 3'd6);
    vecs[3] = mk(AW'(9600), AW'(9600), AW'(9600), AW'(9600), 3'd0, 3'd2, 3'd4, 3'd7);
    vecs[4] = mk('1, '1, '1, '1, 3'd1, 3'd3, 3'd5, 3'd7);

    // The basic case is also checked against the raw words directly.
    check("basic tl from word 0", 64'(vecs[0].exp[0]), 64'(ref_mem[0][7:0]));
    check("basic br from word 40", 64'(vecs[0].exp[3]), 64'(ref_mem[40][15:8]));

    for (int n = 0; n < 5; n++) run_vector($sformatf("vec%0d", n), vecs[n], 1'b0, vnone);

    // Start held for ten edges with all addresses at -1: two results, seven cycles apart.
    vm1 = vecs[4];
    set_inputs(vm1);
    start = 1'b1;
    @(negedge clk);
    npulse = 0; p0 = -1; p1 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (data_valid) begin
        if (npulse == 0) p0 = k;
        else if (npulse == 1) p1 = k;
        npulse++;
      end
      if (k == 9) start = 1'b0;
    end
    check("held start pulse count", 64'(npulse), 64'd2);
    check("held start first pulse", 64'(p0), 64'd6);
    check("held start second pulse", 64'(p1), 64'd13);
    check("held start pixels", 64'(got_pixels()), 64'(vm1.exp));

    // Reset at edge 3 of a fetch aborts it without a result.
    run_vector("pre-reset", vecs[1], 1'b0, vnone);
    set_inputs(vecs[2]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid reset bram_addr", 64'(bram_addr), 64'd0);
    check("mid reset pixels", 64'(got_pixels()), 64'd0);
    npulse = 0;
    for (int k = 4; k <= 14; k++) begin
      @(negedge clk);
      if (data_valid) npulse++;
    end
    check("mid reset no pulse", 64'(npulse), 64'd0);
    check("mid reset pixels stay", 64'(got_pixels()), 64'd0);
    run_vector("post-reset", vecs[2], 1'b0, vnone);

    // Inputs changed before edge 2 must not disturb the latched request.
    va = mk(AW'(7), AW'(9000), AW'(2), AW'(3), 3'd4, 3'd5, 3'd6, 3'd7);
    vb = mk(AW'(500), AW'(501), AW'(502), AW'(503), 3'd0, 3'd0, 3'd0, 3'd0);
    run_vector("input change", va, 1'b1, vb);

    check("bram_we never high", 64'(we_bad), 64'd0);
`ifdef BRAM_READER_RANGE_CHECK_EN
    check("bram_addr in range", 64'(addr_bad), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
